// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: fetch FSM states, default widths
// and the sequencer phase encoding.
package fetch_unit_pkg;

   localparam int FETCH_ADDR_W = 16;
   localparam int FETCH_INST_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

   typedef enum logic [2:0] {
      PH_IF = 3'd1,
      PH_DE = 3'd2,
      PH_RF = 3'd3,
      PH_EX = 3'd4,
      PH_WB = 3'd5
   } seq_phase_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding request, redirect capture.
// Optional fetch abort on memory timeout: define FETCH_TIMEOUT_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W      = FETCH_ADDR_W,
   parameter int                INST_W      = FETCH_INST_W,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                TIMEOUT_CYC = 255
) (
   input  logic              m_clock,
   input  logic              p_reset_n,
   input  logic              start,
   input  logic              fetch_go,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              fault
);

   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_addr;
   logic              r_req;
   logic [INST_W-1:0] r_inst;
   logic              r_valid;
   logic              r_pend_v;
   logic [ADDR_W-1:0] r_pend_a;

   logic [ADDR_W-1:0] w_go_addr;
   logic              w_redir_v;
   logic [ADDR_W-1:0] w_redir_a;

   // A redirect arriving on the ack cycle wins over an older pending one.
   assign w_go_addr = br_taken ? br_target : r_pc;
   assign w_redir_v = br_taken | r_pend_v;
   assign w_redir_a = br_taken ? br_target : r_pend_a;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
   logic [7:0] r_tmo;
   logic       r_fault;
   assign fault = r_fault;
`else
   assign fault = 1'b0;
`endif

   always_ff @(posedge m_clock or negedge p_reset_n) begin
      if (!p_reset_n) begin
         r_state  <= IDLE;
         r_pc     <= RESET_PC;
         r_addr   <= '0;
         r_req    <= 1'b0;
         r_inst   <= '0;
         r_valid  <= 1'b0;
         r_pend_v <= 1'b0;
         r_pend_a <= '0;
`ifdef FETCH_TIMEOUT_EN
         r_tmo    <= '0;
         r_fault  <= 1'b0;
`endif
      end else if (start) begin
         r_state  <= IDLE;
         r_pc     <= RESET_PC;
         r_req    <= 1'b0;
         r_valid  <= 1'b0;
         r_pend_v <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         r_tmo    <= '0;
         r_fault  <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (fetch_go) begin
                  r_state <= WAIT;
                  r_req   <= 1'b1;
                  r_addr  <= w_go_addr;
                  r_pc    <= w_go_addr;
`ifdef FETCH_TIMEOUT_EN
                  r_tmo   <= '0;
`endif
               end else if (br_taken) begin
                  r_pc <= br_target;
               end
               if (br_taken) r_pend_v <= 1'b0;
            end
            WAIT: begin
               if (imem_ack) begin
                  r_state  <= IDLE;
                  r_req    <= 1'b0;
                  r_inst   <= imem_rdata;
                  r_valid  <= 1'b1;
                  r_pend_v <= 1'b0;
                  r_pc     <= w_redir_v ? w_redir_a
                                        : r_pc + ADDR_W'(1);
               end else begin
                  if (br_taken) begin
                     r_pend_v <= 1'b1;
                     r_pend_a <= br_target;
                  end
`ifdef FETCH_TIMEOUT_EN
                  if (r_tmo == TMO_LAST) begin
                     r_state <= IDLE;
                     r_req   <= 1'b0;
                     r_fault <= 1'b1;
                     r_tmo   <= '0;
                  end else begin
                     r_tmo <= r_tmo + 8'd1;
                  end
`endif
               end
            end
         endcase
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_addr;
   assign inst       = r_inst;
   assign inst_valid = r_valid;
   assign pc         = r_pc;
   assign busy       = (r_state == WAIT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {inst, pc} pushed at ack,
// popped by a monitor when inst_valid pulses.
module tb_fetch_unit;

   localparam int AW = 16;
   localparam int IW = 16;

   logic          m_clock = 1'b0;
   logic          p_reset_n;
   logic          start;
   logic          fetch_go;
   logic          br_taken;
   logic [AW-1:0] br_target;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [IW-1:0] imem_rdata;
   logic [IW-1:0] inst;
   logic          inst_valid;
   logic [AW-1:0] pc;
   logic          busy;
   logic          fault;

   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;
   int n_push  = 0;

   logic [IW+AW-1:0] sb_q[$];

   fetch_unit #(
      .ADDR_W(AW), .INST_W(IW), .RESET_PC(16'h0000), .TIMEOUT_CYC(4)
   ) dut (
      .m_clock(m_clock), .p_reset_n(p_reset_n), .start(start),
      .fetch_go(fetch_go), .br_taken(br_taken), .br_target(br_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
      .pc(pc), .busy(busy), .fault(fault)
   );

   always #5 m_clock = ~m_clock;

   always @(negedge m_clock) begin
      if (inst_valid) begin
         logic [IW+AW-1:0] e;
         n_valid++;
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: inst_valid with inst=%h pc=%h, none expected",
                     inst, pc);
         end else begin
            e = sb_q.pop_front();
            if ({inst, pc} !== e) begin
               n_fail++;
               $display("FAIL sb_data: got inst=%h pc=%h, want inst=%h pc=%h",
                        inst, pc, e[IW+AW-1:AW], e[AW-1:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge m_clock);
      #1;
   endtask

   task automatic launch();
      fetch_go = 1'b1;
      tick();
      fetch_go = 1'b0;
   endtask

   task automatic ack_after(input int n, input logic [IW-1:0] d,
                            input logic [AW-1:0] pc_exp);
      repeat (n) tick();
      imem_ack   = 1'b1;
      imem_rdata = d;
      sb_q.push_back({d, pc_exp});
      n_push++;
      tick();
      imem_ack   = 1'b0;
   endtask

   task automatic test_reset();
      p_reset_n = 1'b0;
      #3;
      n_tests++;
      if ({imem_req, imem_addr, inst, inst_valid, pc, busy, fault} !==
          {1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: req=%b addr=%h inst=%h v=%b pc=%h busy=%b fault=%b, want all 0",
                  imem_req, imem_addr, inst, inst_valid, pc, busy, fault);
      end
      tick();
      p_reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      launch();
      n_tests++;
      if ({imem_req, busy, imem_addr} !== {1'b1, 1'b1, 16'h0000}) begin
         n_fail++;
         $display("FAIL basic_req: req=%b busy=%b addr=%h, want 1 1 0000",
                  imem_req, busy, imem_addr);
      end
      ack_after(2, 16'h1234, 16'h0001);
      n_tests++;
      if ({inst, inst_valid, pc, imem_req} !== {16'h1234, 1'b1, 16'h0001, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_done: inst=%h v=%b pc=%h req=%b, want 1234 1 0001 0",
                  inst, inst_valid, pc, imem_req);
      end
      tick();
      n_tests++;
      if ({inst_valid, inst} !== {1'b0, 16'h1234}) begin
         n_fail++;
         $display("FAIL basic_pulse: v=%b inst=%h, want 0 1234", inst_valid, inst);
      end
   endtask

   task automatic test_wrap();
      br_taken = 1'b1; br_target = 16'hFFFF;
      tick();
      br_taken = 1'b0;
      n_tests++;
      if (pc !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL idle_redirect: pc=%h, want ffff", pc);
      end
      launch();
      n_tests++;
      if (imem_addr !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_addr: addr=%h, want ffff", imem_addr);
      end
      ack_after(1, 16'hA5A5, 16'h0000);
      n_tests++;
      if (pc !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_pc: pc=%h, want 0000", pc);
      end
      tick();
   endtask

   task automatic test_redirect_wait();
      br_taken = 1'b1; br_target = 16'h0010;
      tick();
      br_taken = 1'b0;
      launch();
      tick();
      br_taken = 1'b1; br_target = 16'h0040;
      tick();
      br_taken = 1'b0; br_target = 16'h0000;
      n_tests++;
      if ({imem_req, imem_addr, pc} !== {1'b1, 16'h0010, 16'h0010}) begin
         n_fail++;
         $display("FAIL redir_hold: req=%b addr=%h pc=%h, want 1 0010 0010",
                  imem_req, imem_addr, pc);
      end
      ack_after(1, 16'hBEEF, 16'h0040);
      tick();
      launch();
      n_tests++;
      if (imem_addr !== 16'h0040) begin
         n_fail++;
         $display("FAIL redir_next_addr: addr=%h, want 0040", imem_addr);
      end
      ack_after(0, 16'h0101, 16'h0041);
      tick();
   endtask

   task automatic test_br_and_go();
      br_taken = 1'b1; br_target = 16'h0080;
      launch();
      br_taken = 1'b0;
      n_tests++;
      if (imem_addr !== 16'h0080) begin
         n_fail++;
         $display("FAIL brgo_addr: addr=%h, want 0080", imem_addr);
      end
      ack_after(1, 16'h7777, 16'h0081);
      tick();
   endtask

   task automatic test_start();
      launch();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_tests++;
      if ({imem_req, busy, pc, inst, inst_valid} !==
          {1'b0, 1'b0, 16'h0000, 16'h7777, 1'b0}) begin
         n_fail++;
         $display("FAIL start: req=%b busy=%b pc=%h inst=%h v=%b, want 0 0 0000 7777 0",
                  imem_req, busy, pc, inst, inst_valid);
      end
      imem_ack = 1'b1; imem_rdata = 16'hDEAD;
      tick();
      imem_ack = 1'b0;
      tick();
      n_tests++;
      if ({inst, pc, busy} !== {16'h7777, 16'h0000, 1'b0}) begin
         n_fail++;
         $display("FAIL stray_ack: inst=%h pc=%h busy=%b, want 7777 0000 0",
                  inst, pc, busy);
      end
   endtask

   task automatic test_back_to_back();
      int v0;
      int rises;
      logic prev;
      v0    = n_valid;
      rises = 0;
      prev  = imem_req;
      fetch_go = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (imem_req && !prev) rises++;
         prev = imem_req;
      end
      fetch_go = 1'b0;
      n_tests++;
      if ({rises, imem_addr} !== {32'd1, 16'h0000}) begin
         n_fail++;
         $display("FAIL b2b_req: rises=%0d addr=%h, want 1 0000", rises, imem_addr);
      end
      ack_after(0, 16'h4242, 16'h0001);
      tick();
      tick();
      n_tests++;
      if ({n_valid - v0, pc, busy} !== {32'd1, 16'h0001, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_valid: valids=%0d pc=%h busy=%b, want 1 0001 0",
                  n_valid - v0, pc, busy);
      end
   endtask

   task automatic test_reset_midfetch();
      launch();
      tick();
      #1 p_reset_n = 1'b0;
      #1;
      n_tests++;
      if ({imem_req, busy, pc} !== {1'b0, 1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL reset_mid: req=%b busy=%b pc=%h, want 0 0 0000",
                  imem_req, busy, pc);
      end
      tick();
      p_reset_n = 1'b1;
      imem_ack = 1'b1; imem_rdata = 16'h9999;
      tick();
      imem_ack = 1'b0;
      tick();
      n_tests++;
      if ({inst, busy} !== {16'h0000, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_ack: inst=%h busy=%b, want 0000 0", inst, busy);
      end
   endtask

   task automatic test_timeout();
      br_taken = 1'b1; br_target = 16'h0033;
      tick();
      br_taken = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      launch();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_hold%0d: req=%b, want 1", i, imem_req);
         end
      end
      tick();
      n_tests++;
      if ({imem_req, busy, fault, pc} !== {1'b0, 1'b0, 1'b1, 16'h0033}) begin
         n_fail++;
         $display("FAIL tmo_abort: req=%b busy=%b fault=%b pc=%h, want 0 0 1 0033",
                  imem_req, busy, fault, pc);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_tests++;
      if ({fault, pc} !== {1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL tmo_clear: fault=%b pc=%h, want 0 0000", fault, pc);
      end
`else
      launch();
      repeat (20) tick();
      n_tests++;
      if ({imem_req, busy, fault, imem_addr} !== {1'b1, 1'b1, 1'b0, 16'h0033}) begin
         n_fail++;
         $display("FAIL no_tmo: req=%b busy=%b fault=%b addr=%h, want 1 1 0 0033",
                  imem_req, busy, fault, imem_addr);
      end
      ack_after(0, 16'h5A5A, 16'h0034);
      tick();
`endif
   endtask

   task automatic test_drain();
      tick();
      n_tests++;
      if ({sb_q.size(), n_valid} !== {32'd0, n_push}) begin
         n_fail++;
         $display("FAIL drain: left=%0d valids=%0d, want 0 %0d",
                  sb_q.size(), n_valid, n_push);
      end
   endtask

   initial begin
      p_reset_n  = 1'b0;
      start      = 1'b0;
      fetch_go   = 1'b0;
      br_taken   = 1'b0;
      br_target  = '0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      test_reset();
      test_basic();
      test_wrap();
      test_redirect_wait();
      test_br_and_go();
      test_start();
      test_back_to_back();
      test_timeout();
      test_reset_midfetch();
      test_drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
